argmax_accuracy_tracker: RTL and testbench

- Sits directly downstream of the output-layer max finder.
- Each valid cycle it takes the predicted class (argmax position) and the max activation, and compares the position against the sample's ground-truth label.
- Counts correct predictions over fixed windows of WINDOW samples, plus running totals, for on-chip accuracy monitoring during training/inference.

---
 rtl/argmax_accuracy_tracker.sv | 115 +++++++++++
 tb/tb_argmax_accuracy_tracker.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/argmax_accuracy_tracker.sv
// argmax_accuracy_tracker: windowed and running accuracy counters for argmax predictions.
// Optional macro LOW_CONF_EN adds low-confidence counting (win_lowconf, last_lowconf).
// Ports: clk, reset_n (sync, active-low); start (window begin/restart pulse); continuous
// (auto-restart after completion); in_valid/pred_pos/pred_val/label (sample in);
// busy (RUN state); last_hit (last counted sample correct); win_done (completion pulse);
// win_correct (last window's correct count); total_samples/total_correct (saturating
// totals since reset); range_err (sticky out-of-range index).
module argmax_accuracy_tracker #(
  parameter int width       = 13,
  parameter int N           = 37,
  parameter int poswidth    = $clog2(N),
  parameter int WINDOW      = 100,
  parameter int cntwidth    = $clog2(WINDOW + 1),
  parameter int totwidth    = 32,
  parameter int CONF_THRESH = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       continuous,
  input  logic                       in_valid,
  input  logic        [poswidth-1:0] pred_pos,
  input  logic signed [width-1:0]    pred_val,
  input  logic        [poswidth-1:0] label,
  output logic                       busy,
  output logic                       last_hit,
  output logic                       win_done,
  output logic        [cntwidth-1:0] win_correct,
  output logic        [totwidth-1:0] total_samples,
  output logic        [totwidth-1:0] total_correct,
`ifdef LOW_CONF_EN
  output logic        [cntwidth-1:0] win_lowconf,
  output logic                       last_lowconf,
`endif
  output logic                       range_err
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  // one extra bit so N == 2**poswidth still compares correctly
  localparam logic [poswidth:0] NL = (poswidth + 1)'(N);
  state_t state_q;
  logic last_hit_q, win_done_q, range_err_q;
  logic [cntwidth-1:0] win_cnt_q, win_hit_q, win_hit_d, win_correct_q;
  logic [totwidth-1:0] tot_s_q, tot_c_q, tot_s_d, tot_c_d;
  logic in_rng, hit, count, wrap;
  assign in_rng = ({1'b0, pred_pos} < NL) && ({1'b0, label} < NL);
  assign hit = in_rng && (pred_pos == label);
  // a start cycle always drops its sample
  assign count = (state_q == RUN) && in_valid && !start;
  assign wrap = count && (win_cnt_q == cntwidth'(WINDOW - 1));
  assign win_hit_d = win_hit_q + cntwidth'(hit);
  assign tot_s_d = &tot_s_q ? tot_s_q : tot_s_q + totwidth'(1);
  assign tot_c_d = (&tot_c_q || !hit) ? tot_c_q : tot_c_q + totwidth'(1);
`ifdef LOW_CONF_EN
  logic last_lc_q, lc;
  logic [cntwidth-1:0] win_lc_q, win_lc_acc_q, win_lc_d;
  assign lc = int'(pred_val) < CONF_THRESH;
  assign win_lc_d = win_lc_acc_q + cntwidth'(lc);
  assign win_lowconf = win_lc_q;
  assign last_lowconf = last_lc_q;
`else
  logic unused_pred_val;
  assign unused_pred_val = ^pred_val;
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_hit_q <= 1'b0;
      win_done_q <= 1'b0;
      range_err_q <= 1'b0;
      win_cnt_q <= '0;
      win_hit_q <= '0;
      win_correct_q <= '0;
      tot_s_q <= '0;
      tot_c_q <= '0;
`ifdef LOW_CONF_EN
      last_lc_q <= 1'b0;
      win_lc_q <= '0;
      win_lc_acc_q <= '0;
`endif
    end else begin
      win_done_q <= wrap;
      if (start) begin
        state_q <= RUN;
        win_cnt_q <= '0;
        win_hit_q <= '0;
`ifdef LOW_CONF_EN
        win_lc_acc_q <= '0;
`endif
      end else if (count) begin
        last_hit_q <= hit;
        range_err_q <= range_err_q | !in_rng;
        tot_s_q <= tot_s_d;
        tot_c_q <= tot_c_d;
        win_cnt_q <= wrap ? '0 : win_cnt_q + cntwidth'(1);
        win_hit_q <= wrap ? '0 : win_hit_d;
`ifdef LOW_CONF_EN
        last_lc_q <= lc;
        win_lc_acc_q <= wrap ? '0 : win_lc_d;
        if (wrap) win_lc_q <= win_lc_d;
`endif
        if (wrap) begin
          win_correct_q <= win_hit_d;
          state_q <= continuous ? RUN : HOLD;
        end
      end
    end
  end
  assign busy = state_q == RUN;
  assign last_hit = last_hit_q;
  assign win_done = win_done_q;
  assign win_correct = win_correct_q;
  assign total_samples = tot_s_q;
  assign total_correct = tot_c_q;
  assign range_err = range_err_q;
endmodule

// File: tb/tb_argmax_accuracy_tracker.sv
// tb_argmax_accuracy_tracker: directed bench with a queue-based accuracy model.
module tb_argmax_accuracy_tracker;
  localparam int WIN = 4;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, continuous = 1'b0, in_valid = 1'b0;
  logic [5:0] pred_pos = '0, label = '0;
  logic signed [12:0] pred_val = '0;
  logic busy, last_hit, win_done, range_err;
  logic [2:0] win_correct;
  logic [31:0] total_samples, total_correct;
`ifdef LOW_CONF_EN
  logic [2:0] win_lowconf;
  logic last_lowconf;
`endif
  int tests = 0, fails = 0;

  argmax_accuracy_tracker #(.WINDOW(WIN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
    .in_valid(in_valid), .pred_pos(pred_pos), .pred_val(pred_val), .label(label),
    .busy(busy), .last_hit(last_hit), .win_done(win_done), .win_correct(win_correct),
    .total_samples(total_samples), .total_correct(total_correct),
`ifdef LOW_CONF_EN
    .win_lowconf(win_lowconf), .last_lowconf(last_lowconf),
`endif
    .range_err(range_err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model: mode 0=idle 1=run 2=hold; current window kept as a list of sample results
  int mode = 0, e_wc = 0, e_wlc = 0;
  bit wq[$];
  bit lq[$];
  longint ts = 0, tc = 0;
  bit e_last = 0, e_done = 0, e_rerr = 0, e_llc = 0, seen_reset = 0;
  localparam longint TMAX = 64'hFFFF_FFFF;

  task automatic model_step();
    bit h, rng, lc;
    int s;
    if (!reset_n) begin
      seen_reset = 1; mode = 0; wq.delete(); lq.delete();
      ts = 0; tc = 0; e_last = 0; e_done = 0; e_rerr = 0; e_wc = 0; e_wlc = 0; e_llc = 0;
      return;
    end
    e_done = 0;
    if (start) begin
      mode = 1; wq.delete(); lq.delete();
    end else if (mode == 1 && in_valid) begin
      rng = (pred_pos < 37) && (label < 37);
      h = rng && (pred_pos == label);
      lc = pred_val < 0;
      e_last = h; e_llc = lc;
      if (!rng) e_rerr = 1;
      if (ts < TMAX) ts++;
      if (h && tc < TMAX) tc++;
      wq.push_back(h); lq.push_back(lc);
      if (wq.size() == WIN) begin
        s = 0; foreach (wq[i]) s += int'(wq[i]); e_wc = s;
        s = 0; foreach (lq[i]) s += int'(lq[i]); e_wlc = s;
        e_done = 1; wq.delete(); lq.delete();
        if (!continuous) mode = 2;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (seen_reset) begin
      chk("busy", 64'(busy), 64'(mode == 1));
      chk("last_hit", 64'(last_hit), 64'(e_last));
      chk("win_done", 64'(win_done), 64'(e_done));
      chk("win_correct", 64'(win_correct), 64'(e_wc));
      chk("total_samples", 64'(total_samples), 64'(ts));
      chk("total_correct", 64'(total_correct), 64'(tc));
      chk("range_err", 64'(range_err), 64'(e_rerr));
`ifdef LOW_CONF_EN
      chk("win_lowconf", 64'(win_lowconf), 64'(e_wlc));
      chk("last_lowconf", 64'(last_lowconf), 64'(e_llc));
`endif
    end
  end

  task automatic cyc(input bit st, input bit iv, input int pp, input int lb, input int pv = 0);
    start = st; in_valid = iv; pred_pos = 6'(pp); label = 6'(lb); pred_val = 13'(pv);
    @(negedge clk);
  endtask

  initial begin
    int p1[4] = '{3, 5, 7, 36};
    int l1[4] = '{3, 5, 2, 36};
    int v6[4] = '{-5, 0, 12, -4096};
    reset_n = 0;
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    reset_n = 1;
    for (int i = 0; i < 5; i++) cyc(0, 1, 4, 4);
    chk("idle_busy", 64'(busy), 0);
    chk("idle_total", 64'(total_samples), 0);
    // single window, hold afterwards; start-cycle sample dropped
    continuous = 0;
    cyc(1, 1, 1, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, p1[i], l1[i]);
    chk("w1_done", 64'(win_done), 1);
    chk("w1_correct", 64'(win_correct), 3);
    chk("w1_samples", 64'(total_samples), 4);
    chk("w1_busy", 64'(busy), 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 9, 9);
    chk("hold_samples", 64'(total_samples), 4);
    chk("hold_done", 64'(win_done), 0);
    // continuous: two back-to-back windows
    continuous = 1;
    cyc(1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, i, i);
      if (i == 4 || i == 5 || i == 8) chk("cont_done", 64'(win_done), 64'(i != 5));
    end
    chk("cont_correct", 64'(win_correct), 4);
    chk("cont_total_correct", 64'(total_correct), 11);
    chk("cont_busy", 64'(busy), 1);
    // restart mid-window
    continuous = 0;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 2, 2); cyc(0, 1, 3, 3);
    cyc(1, 1, 4, 4);
    cyc(0, 1, 10, 10); cyc(0, 1, 11, 12); cyc(0, 1, 12, 12);
    chk("rs_not_done", 64'(win_done), 0);
    cyc(0, 1, 13, 13);
    chk("rs_done", 64'(win_done), 1);
    chk("rs_correct", 64'(win_correct), 3);
    chk("rs_samples", 64'(total_samples), 18);
    // out-of-range indices
    cyc(1, 0, 0, 0);
    cyc(0, 1, 37, 37);
    chk("rng_hit", 64'(last_hit), 0);
    chk("rng_err", 64'(range_err), 1);
    cyc(0, 1, 63, 5);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rng_sticky", 64'(range_err), 1);
    reset_n = 0; cyc(0, 0, 0, 0); reset_n = 1;
    chk("rng_cleared", 64'(range_err), 0);
    chk("rst_total", 64'(total_correct), 0);
    // low-confidence window (only checked when compiled in)
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 6, 6, v6[i]);
`ifdef LOW_CONF_EN
    chk("lc_count", 64'(win_lowconf), 2);
`endif
    chk("lc_correct", 64'(win_correct), 4);
    cyc(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
